// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin arbiter sharing one 2N-bit adder, with same-operand dedupe and per-requester result slots
module shared_adder_arbiter #(
  parameter int N = 16,
  parameter int NREQ = 2
) (
  input  logic                  IN_clk,
  input  logic                  IN_rst_n,
  input  logic [NREQ-1:0]       IN_reqValid,
  input  logic [NREQ*2*N-1:0]   IN_reqA,
  input  logic [NREQ*2*N-1:0]   IN_reqB,
  input  logic [NREQ-1:0]       IN_reqWide,
  output logic [NREQ-1:0]       OUT_reqReady,
  output logic [NREQ-1:0]       OUT_resValid,
  output logic [NREQ*2*N-1:0]   OUT_res,
  input  logic [NREQ-1:0]       IN_resReady,
  output logic [15:0]           OUT_dedupeCnt
);
  localparam int W = 2 * N;
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_q, rr_d;
  logic [NREQ-1:0] res_valid_q, res_valid_d, elig, ready;
  logic [NREQ*W-1:0] res_q, res_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;
  logic [W-1:0] win_a, win_b, sum;
  logic found;
  int win, idx, co;
  always_comb begin
    elig = IN_reqValid & (~res_valid_q | IN_resReady);
    found = 1'b0;
    win = 0;
    idx = 0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
        win_a = IN_reqA[idx*W +: W];
        win_b = IN_reqB[idx*W +: W];
      end
    end
    sum = win_a + win_b;
    ready = '0;
    co = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (found && elig[j] && (j == win || (IN_reqA[j*W +: W] == win_a && IN_reqB[j*W +: W] == win_b))) begin
        ready[j] = 1'b1;
        co = co + ((j != win) ? 1 : 0);
      end
    end
    rr_d = found ? PW'((win + 1) % NREQ) : rr_q;
    res_valid_d = ready | (res_valid_q & ~IN_resReady);
    res_d = res_q;
    for (int i = 0; i < NREQ; i++)
      if (ready[i]) res_d[i*W +: W] = IN_reqWide[i] ? sum : {{N{1'b0}}, sum[N-1:0]};
    cnt_sum = {1'b0, cnt_q} + 17'(co);
    cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      rr_q <= '0;
      res_valid_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_q <= rr_d;
      res_valid_q <= res_valid_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end
  assign OUT_reqReady = ready;
  assign OUT_resValid = res_valid_q;
  assign OUT_res = res_q;
  assign OUT_dedupeCnt = cnt_q;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: randomized scoreboard bench for shared_adder_arbiter
module tb_shared_adder_arbiter;
  localparam int N = 16;
  localparam int NREQ = 2;
  localparam int W = 32;
  typedef struct {
    logic [31:0] val;
    int cyc;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] v = '0, wide = '0, rrdy = '0;
  logic [63:0] a_in = '0, b_in = '0;
  logic [1:0] req_ready, res_valid;
  logic [63:0] res;
  logic [15:0] dcnt;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int m_rr = 0, m_cnt = 0;
  ent_t q[NREQ][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  shared_adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .IN_clk(clk), .IN_rst_n(rst_n), .IN_reqValid(v), .IN_reqA(a_in), .IN_reqB(b_in),
    .IN_reqWide(wide), .OUT_reqReady(req_ready), .OUT_resValid(res_valid), .OUT_res(res),
    .IN_resReady(rrdy), .OUT_dedupeCnt(dcnt)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic bit slot_full(input int i);
    return q[i].size() > 0 && q[i][0].cyc < cyc;
  endfunction
  task automatic step(input logic [1:0] vv, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] ww, input logic [1:0] rd);
    logic [31:0] aa[NREQ], bb[NREQ], s;
    bit el[NREQ];
    logic [1:0] er;
    int win, ded;
    ent_t e;
    @(negedge clk);
    v = vv; a_in = {a1, a0}; b_in = {b1, b0}; wide = ww; rrdy = rd;
    #1;
    aa[0] = a0; aa[1] = a1; bb[0] = b0; bb[1] = b1;
    for (int i = 0; i < NREQ; i++) el[i] = vv[i] && (!slot_full(i) || rd[i]);
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && el[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
    er = '0;
    ded = 0;
    if (win >= 0) begin
      s = aa[win] + bb[win];
      for (int j = 0; j < NREQ; j++)
        if (el[j] && (j == win || (aa[j] == aa[win] && bb[j] == bb[win]))) begin
          er[j] = 1'b1;
          if (j != win) ded++;
          e.val = ww[j] ? s : (s & 32'h0000FFFF);
          e.cyc = cyc;
          q[j].push_back(e);
        end
    end
    chk("dedupe_cnt", dcnt, m_cnt);
    chk("req_ready", req_ready, er);
    if (win >= 0) m_rr = (win + 1) % NREQ;
    m_cnt = (m_cnt + ded > 65535) ? 65535 : m_cnt + ded;
  endtask
  always begin
    bit pv;
    @(negedge clk);
    #4;
    if (rst_n)
      for (int i = 0; i < NREQ; i++) begin
        pv = slot_full(i);
        chk($sformatf("res_valid%0d", i), res_valid[i], pv);
        if (pv) begin
          chk($sformatf("res%0d", i), res[i*W +: W], q[i][0].val);
          if (rrdy[i]) void'(q[i].pop_front());
        end
      end
  end
  initial begin
    logic [31:0] p0, p1, r0, r1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_cnt", dcnt, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(2'b01, 32'h0001FFFF, 32'h1, 0, 0, 2'b00, 2'b11);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    step(2'b01, 32'h0001FFFF, 32'h1, 0, 0, 2'b01, 2'b11);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    step(2'b11, 32'h00018000, 32'h8000, 32'h00018000, 32'h8000, 2'b10, 2'b11);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    chk("dedupe_once", dcnt, 1);
    for (int k = 0; k < 4; k++) step(2'b11, 32'h100 + k, 32'h5, 32'h200 + k, 32'h7, 2'b11, 2'b11);
    step(2'b01, 32'h1234, 32'h1, 0, 0, 2'b01, 2'b11);
    for (int k = 0; k < 4; k++) step(2'b11, 32'h11, 32'h22, 32'h300 + k, 32'h1, 2'b11, 2'b10);
    step(2'b11, 32'hABCD0000, 32'h1, 32'h5, 32'h6, 2'b01, 2'b11);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    step(2'b01, 32'hFFFFFFFF, 32'h1, 0, 0, 2'b01, 2'b11);
    step(2'b10, 0, 0, 32'h0000FFFF, 32'h2, 2'b00, 2'b11);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    for (int k = 0; k < 400; k++) begin
      p0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      r0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      p1 = ($urandom_range(0, 2) != 0) ? p0 : $urandom_range(0, 3);
      r1 = ($urandom_range(0, 2) != 0) ? r0 : $urandom_range(0, 3);
      step(2'($urandom), p0, r0, p1, r1, 2'($urandom),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
    end
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    step(2'b01, 32'h10, 32'h20, 0, 0, 2'b01, 2'b11);
    step(2'b11, 32'h7, 32'h8, 32'h7, 32'h8, 2'b11, 2'b00);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    chk("pre_rst_valid", res_valid, 2'b11);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    m_rr = 0;
    m_cnt = 0;
    #1;
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_res", res, 0);
    chk("async_rst_cnt", dcnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 2'b11, 2'b11);
    chk("post_rst_winner", req_ready, 2'b01);
    step(2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 2'b11, 2'b11);
    repeat (3) step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11);
    for (int i = 0; i < NREQ; i++) chk($sformatf("drained%0d", i), q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
